// File: rtl/bp_cacc_coh_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one coherence NoC link among tiles.
// Grant locks at a header flit and is held until the last body flit is accepted.
module bp_cacc_coh_link_arbiter #(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 64,
    parameter int cord_width_p = 7,
    parameter int len_width_p  = 4,
    localparam int id_width_lp = $clog2(num_req_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    input  logic [num_req_p-1:0]              v_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic [flit_width_p-1:0]           data_o,
    output logic                              v_o,
    input  logic                              ready_and_i,
    output logic [id_width_lp-1:0]            grant_id_o,
    output logic                              busy_o
);

    typedef enum logic [1:0] {e_idle, e_offer, e_busy} state_e;

    state_e                 state_q, state_d;
    logic [id_width_lp-1:0] rr_ptr_q, rr_ptr_d;
    logic [id_width_lp-1:0] owner_q, owner_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;

    logic [id_width_lp-1:0]  winner;
    logic                    found;
    int                      cand;
    logic [id_width_lp-1:0]  sel;
    logic [flit_width_p-1:0] sel_data;
    logic [len_width_p-1:0]  hdr_len;
    logic                    sel_v;
    logic                    hs;

    function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] id);
        return (id == id_width_lp'(num_req_p - 1)) ? '0 : id + 1'b1;
    endfunction

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        for (int i = 0; i < num_req_p; i++) begin
            cand = (int'(rr_ptr_q) + i) % num_req_p;
            if (!found && v_i[cand]) begin
                winner = id_width_lp'(cand);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel         = (state_q == e_idle) ? winner : owner_q;
        sel_data    = data_i[int'(sel)*flit_width_p +: flit_width_p];
        sel_v       = v_i[sel];
        hdr_len     = sel_data[cord_width_p +: len_width_p];
        data_o      = sel_data;
        v_o         = sel_v & ~reset_i;
        ready_and_o = '0;
        ready_and_o[sel] = ready_and_i & ~reset_i;
        hs          = v_o & ready_and_i;
        grant_id_o  = reset_i ? '0 : sel;
        busy_o      = ~reset_i & ((state_q == e_busy) ||
                                  ((state_q == e_offer) && (hdr_len != '0)));
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        case (state_q)
            e_idle, e_offer: begin
                if (hs) begin
                    if (hdr_len == '0) begin
                        state_d  = e_idle;
                        rr_ptr_d = next_id(sel);
                    end else begin
                        state_d = e_busy;
                        owner_d = sel;
                        cnt_d   = hdr_len;
                    end
                end else if (state_q == e_idle && sel_v) begin
                    // Park on the stalled winner so data_o cannot change under the link.
                    state_d = e_offer;
                    owner_d = sel;
                end
            end
            e_busy: begin
                if (hs) begin
                    if (cnt_q <= len_width_p'(1)) begin
                        state_d  = e_idle;
                        cnt_d    = '0;
                        rr_ptr_d = next_id(owner_q);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= e_idle;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule
